mc_datapath: RTL and testbench

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath.sv | 197 +++++++++++++++++++
 tb/tb_mc_datapath.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// Multi-cycle RV datapath (IDLE/DECODE/EXEC/MEM/WB); handshake-to-done is 3 (BEQ), 4 (ALU, store), 5 (load) cycles.
// Backpressure: inst_ready is high only in IDLE, so a new instruction waits until the previous one retires.
module mc_datapath #(
  parameter int              XLEN     = 64,
  parameter int              DM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     inst,
  input  logic            inst_valid,
  output logic            inst_ready,
  output logic            done,
  output logic            illegal,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instret,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  localparam int              BSHIFT = $clog2(XLEN / 8);
  localparam int              DMW    = $clog2(DM_DEPTH);
  localparam logic [2:0]      MEM_F3 = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [XLEN-1:0] FOUR   = XLEN'(4);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_t;
  typedef struct packed {
    logic legal;
    logic rtype;
    logic ld;
    logic sd;
    logic beq;
    alu_t alu;
  } dec_t;

  state_t          state, state_nxt;
  dec_t            dec;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, imm, aluout, mdr;
  logic [XLEN-1:0] opb, alu_res;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] dm [DM_DEPTH];
  logic [DMW-1:0]  dm_idx;

  // Decode is purely from IR, which is stable from DECODE until the next handshake.
  always_comb begin
    dec     = '0;
    dec.alu = ALU_ADD;
    case (ir[6:0])
      7'b0110011: begin
        dec.rtype = 1'b1;
        dec.legal = 1'b1;
        case ({ir[31:25], ir[14:12]})
          10'b0000000_000: dec.alu = ALU_ADD;
          10'b0100000_000: dec.alu = ALU_SUB;
          10'b0000000_111: dec.alu = ALU_AND;
          10'b0000000_110: dec.alu = ALU_OR;
          10'b0000000_100: dec.alu = ALU_XOR;
          10'b0000000_010: dec.alu = ALU_SLT;
          default:         dec.legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.legal = 1'b1;
        case (ir[14:12])
          3'b000:  dec.alu = ALU_ADD;
          3'b111:  dec.alu = ALU_AND;
          3'b110:  dec.alu = ALU_OR;
          default: dec.legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec.ld    = (ir[14:12] == MEM_F3);
        dec.legal = dec.ld;
      end
      7'b0100011: begin
        dec.sd    = (ir[14:12] == MEM_F3);
        dec.legal = dec.sd;
      end
      7'b1100011: begin
        dec.beq   = (ir[14:12] == 3'b000);
        dec.legal = dec.beq;
      end
      default: dec.legal = 1'b0;
    endcase
  end

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  assign opb = dec.rtype ? b : imm;

  always_comb begin
    alu_res = '0;
    case (dec.alu)
      ALU_ADD: alu_res = a + opb;
      ALU_SUB: alu_res = a - opb;
      ALU_AND: alu_res = a & opb;
      ALU_OR:  alu_res = a | opb;
      ALU_XOR: alu_res = a ^ opb;
      ALU_SLT: alu_res[0] = ($signed(a) < $signed(opb));
      default: alu_res = '0;
    endcase
  end

  // Byte address to word index; high bits are dropped so any address wraps into the array.
  assign dm_idx = aluout[BSHIFT +: DMW];

  // done/illegal are gated by reset so an aborted instruction never reports.
  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state)
      IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (dec.legal) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
          illegal   = !reset;
        end
      end
      EXEC: begin
        if (dec.beq) begin
          state_nxt = IDLE;
          done      = !reset;
        end else if (dec.ld || dec.sd) begin
          state_nxt = MEM;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        if (dec.sd) begin
          state_nxt = IDLE;
          done      = !reset;
        end else begin
          state_nxt = WB;
        end
      end
      WB: begin
        state_nxt = IDLE;
        done      = !reset;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instret <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (done) instret <= instret + 32'd1;
      case (state)
        IDLE: if (inst_valid) ir <= inst;
        DECODE: begin
          a   <= regs[ir[19:15]];
          b   <= regs[ir[24:20]];
          imm <= dec.sd ? imm_s : (dec.beq ? imm_b : imm_i);
          if (!dec.legal) pc <= pc + FOUR;
        end
        EXEC: begin
          aluout <= alu_res;
          if (dec.beq) pc <= (a == b) ? pc + imm : pc + FOUR;
        end
        MEM: if (dec.sd) pc <= pc + FOUR;
        WB: begin
          if (ir[11:7] != 5'd0) regs[ir[11:7]] <= dec.ld ? mdr : aluout;
          pc <= pc + FOUR;
        end
        default: ;
      endcase
    end
  end

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && state == MEM) begin
      if (dec.sd) dm[dm_idx] <= b;
      else        mdr <= dm[dm_idx];
    end
  end

  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: tb/tb_mc_datapath.sv
// Randomized bench for mc_datapath against an instruction-level reference model.
module tb_mc_datapath;
  localparam int XLEN     = 64;
  localparam int DM_DEPTH = 256;
  localparam int K_DONE   = 1;
  localparam int K_ILL    = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     inst = '0;
  logic            inst_valid = 1'b0;
  logic            inst_ready, done, illegal;
  logic [XLEN-1:0] pc, dbg_rdata;
  logic [31:0]     instret;
  logic [4:0]      dbg_raddr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mreg [32];
  logic [63:0] mdm  [DM_DEPTH];
  logic [63:0] mpc;
  logic [31:0] minstret;

  mc_datapath #(.XLEN(XLEN), .DM_DEPTH(DM_DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .done(done), .illegal(illegal), .pc(pc),
    .instret(instret), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), f3, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic int widx(input logic [63:0] addr);
    return int'((addr / 8) % DM_DEPTH);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mpc      = '0;
    minstret = '0;
  endfunction

  // Architectural effect of one instruction, straight from the ISA rules.
  task automatic model_step(input logic [31:0] w, output int exp_cyc, output int exp_kind);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [63:0] va, vb, ii, is, ib, res;
    int          rd;
    bit          ok, wr, br;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; rd = int'(w[11:7]);
    va = mreg[w[19:15]];
    vb = mreg[w[24:20]];
    ii = 64'($signed(w[31:20]));
    is = 64'($signed({w[31:25], w[11:7]}));
    ib = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    ok = 0; wr = 0; br = 0; res = '0; exp_cyc = 2;
    case (op)
      7'h33: begin
        exp_cyc = 4; wr = 1; ok = 1;
        if (f7 == 7'h20 && f3 == 3'd0) res = va - vb;
        else if (f7 != 7'h00) ok = 0;
        else if (f3 == 3'd0) res = va + vb;
        else if (f3 == 3'd7) res = va & vb;
        else if (f3 == 3'd6) res = va | vb;
        else if (f3 == 3'd4) res = va ^ vb;
        else if (f3 == 3'd2) res = ($signed(va) < $signed(vb)) ? 64'd1 : 64'd0;
        else ok = 0;
      end
      7'h13: begin
        exp_cyc = 4; wr = 1; ok = 1;
        if (f3 == 3'd0) res = va + ii;
        else if (f3 == 3'd7) res = va & ii;
        else if (f3 == 3'd6) res = va | ii;
        else ok = 0;
      end
      7'h03: if (f3 == 3'd3) begin ok = 1; wr = 1; exp_cyc = 5; res = mdm[widx(va + ii)]; end
      7'h23: if (f3 == 3'd3) begin ok = 1; exp_cyc = 4; mdm[widx(va + is)] = vb; end
      7'h63: if (f3 == 3'd0) begin ok = 1; br = 1; exp_cyc = 3; end
      default: ok = 0;
    endcase
    if (!ok) begin
      exp_cyc  = 2;
      exp_kind = K_ILL;
      mpc      = mpc + 4;
    end else begin
      exp_kind = K_DONE;
      minstret = minstret + 1;
      mpc      = (br && va == vb) ? mpc + ib : mpc + 4;
      if (wr && rd != 0) mreg[rd] = res;
    end
  endtask

  task automatic read_reg(input int i, output logic [63:0] v);
    dbg_raddr = 5'(i);
    #1;
    v = dbg_rdata;
  endtask

  task automatic run_inst(input logic [31:0] w);
    int          exp_cyc, exp_kind, cyc, kind;
    logic [63:0] v;
    model_step(w, exp_cyc, exp_kind);
    @(negedge clk);
    check_eq("ready_before", inst_ready, 1);
    inst = w;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    inst = $urandom;
    cyc = 2; kind = 0;
    while (cyc < 12) begin
      if (done || illegal) begin
        kind = (done && illegal) ? 3 : (done ? K_DONE : K_ILL);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("event_kind", kind, exp_kind);
    check_eq("latency", cyc, exp_cyc);
    @(posedge clk); #1;
    check_eq("idle_after", {inst_ready, done, illegal}, 3'b100);
    check_eq("pc", pc, mpc);
    check_eq("instret", instret, minstret);
    read_reg(int'(w[11:7]), v);
    check_eq("rd_value", v, mreg[w[11:7]]);
  endtask

  // Reset lands while the instruction sits in its final state (WB or MEM).
  task automatic abort_in_final(input logic [31:0] w);
    @(negedge clk);
    inst = w;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("abort_pre_done", done, 1);
    reset = 1'b1;
    #1;
    check_eq("abort_done_gated", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_eq("abort_ready", inst_ready, 1);
    check_eq("abort_pc", pc, 0);
    check_eq("abort_instret", instret, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    int          rd, rs1, rs2, sel;
    logic [31:0] w;
    rd  = $urandom_range(0, 31);
    rs1 = $urandom_range(0, 31);
    rs2 = $urandom_range(0, 31);
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: case ($urandom_range(0, 5))
        0: w = enc_r(7'h00, rs2, rs1, 3'd0, rd);
        1: w = enc_r(7'h20, rs2, rs1, 3'd0, rd);
        2: w = enc_r(7'h00, rs2, rs1, 3'd7, rd);
        3: w = enc_r(7'h00, rs2, rs1, 3'd6, rd);
        4: w = enc_r(7'h00, rs2, rs1, 3'd4, rd);
        default: w = enc_r(7'h00, rs2, rs1, 3'd2, rd);
      endcase
      3, 4, 9: begin
        case ($urandom_range(0, 2))
          0: w = enc_i($urandom_range(0, 4095), rs1, 3'd0, rd, 7'h13);
          1: w = enc_i($urandom_range(0, 4095), rs1, 3'd7, rd, 7'h13);
          default: w = enc_i($urandom_range(0, 4095), rs1, 3'd6, rd, 7'h13);
        endcase
      end
      5: w = enc_i(8 * ($urandom_range(0, 15) - 8), 0, 3'd3, rd, 7'h03);
      6: w = enc_s(8 * ($urandom_range(0, 15) - 8), rs2, 0, 3'd3);
      7: w = enc_b(2 * $urandom_range(0, 63) - 64, ($urandom_range(0, 1) != 0) ? rs1 : rs2, rs1, 3'd0);
      default: case ($urandom_range(0, 4))
        0: w = ($urandom & 32'hFFFF_FF80) | 32'h7F;
        1: w = enc_r(7'h01, rs2, rs1, 3'd0, rd);
        2: w = enc_i(5, rs1, 3'd1, rd, 7'h13);
        3: w = enc_i(0, rs1, 3'd2, rd, 7'h03);
        default: w = enc_b(8, rs2, rs1, 3'd1);
      endcase
    endcase
    return w;
  endfunction

  initial begin
    logic [63:0] v;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_ready", inst_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_instret", instret, 0);
    read_reg(1, v);
    check_eq("rst_x1", v, 0);

    run_inst(enc_i(5, 0, 3'd0, 1, 7'h13));
    run_inst(enc_i(-3, 0, 3'd0, 2, 7'h13));
    run_inst(enc_r(7'h00, 2, 1, 3'd0, 3));
    read_reg(3, v);
    check_eq("add_x3", v, 64'd2);
    check_eq("seq_pc", pc, 64'd12);
    check_eq("seq_instret", instret, 32'd3);

    run_inst(enc_r(7'h20, 1, 2, 3'd0, 4));
    read_reg(4, v);
    check_eq("sub_x4", v, -64'sd8);
    run_inst(enc_r(7'h00, 1, 2, 3'd2, 5));
    read_reg(5, v);
    check_eq("slt_x5", v, 64'd1);

    check_eq("beq_start_pc", pc, 64'd20);
    run_inst(enc_b(-8, 1, 1, 3'd0));
    check_eq("beq_taken_pc", pc, 64'd12);
    run_inst(enc_b(8, 2, 1, 3'd0));
    check_eq("beq_not_taken_pc", pc, 64'd16);

    run_inst(enc_i(7, 0, 3'd0, 0, 7'h13));
    read_reg(0, v);
    check_eq("x0_zero", v, 0);

    run_inst(enc_s(16, 3, 0, 3'd3));
    run_inst(enc_i(16, 0, 3'd3, 6, 7'h03));
    read_reg(6, v);
    check_eq("ld_x6", v, 64'd2);
    run_inst(enc_i(2047, 0, 3'd0, 8, 7'h13));
    run_inst(enc_i(17, 8, 3'd0, 8, 7'h13));
    run_inst(enc_s(0, 5, 8, 3'd3));
    run_inst(enc_i(16, 0, 3'd3, 9, 7'h03));
    read_reg(9, v);
    check_eq("alias_x9", v, 64'd1);

    run_inst(32'h0000_057F);
    check_eq("ill_instret", instret, minstret);

    abort_in_final(enc_r(7'h00, 1, 1, 3'd0, 7));
    read_reg(7, v);
    check_eq("abort_x7", v, 0);
    run_inst(enc_i(99, 0, 3'd0, 10, 7'h13));
    abort_in_final(enc_s(16, 10, 0, 3'd3));
    run_inst(enc_i(16, 0, 3'd3, 11, 7'h03));
    read_reg(11, v);
    check_eq("abort_no_store", v, 64'd1);

    for (int i = 1; i < 32; i++) run_inst(enc_i($urandom_range(0, 4095), 0, 3'd0, i, 7'h13));
    for (int k = -8; k < 8; k++) run_inst(enc_s(8 * k, $urandom_range(0, 31), 0, 3'd3));
    for (int n = 0; n < 200; n++) run_inst(rand_inst());

    for (int i = 0; i < 32; i++) begin
      read_reg(i, v);
      check_eq("final_reg", v, mreg[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
